// File: rtl/pll_drp_ctrl.sv
// DRP read-modify-write sequencer for the fabric PLL: holds the PLL in reset while a
// stream of masked register updates is applied, then releases it and waits for lock.
module pll_drp_ctrl #(
   parameter int DRDY_TIMEOUT = 64,
   parameter int RST_HOLD     = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        drp_dclk,
   input  logic        free_run_rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  req_daddr,
   input  logic [15:0] req_mask,
   input  logic [15:0] req_data,
   input  logic        req_last,
   output logic [6:0]  drp_daddr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   output logic        drp_den,
   output logic        drp_dwe,
   input  logic        drp_drdy,
   output logic        pll_rst,
   input  logic        locked,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [3:0] {
      IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, LOCK_WAIT
   } state_t;

   localparam logic [1:0]  ERR_DRDY   = 2'd1;
   localparam logic [1:0]  ERR_LOCK   = 2'd2;
   localparam logic [15:0] HOLD_LOAD  = 16'(RST_HOLD - 1);
   localparam logic [15:0] DRDY_LIMIT = 16'(DRDY_TIMEOUT - 1);
   localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] mask_q;
   logic [15:0] data_q;
   logic        last_q;
   logic        take;

   assign take = req_valid && req_ready;

   // NOTE: entry payload registers carry no reset; they are only read after a handshake loads them.
   always_ff @(posedge drp_dclk) begin
      if (take) begin
         mask_q <= req_mask;
         data_q <= req_data;
         last_q <= req_last;
      end
   end

   // NOTE: all state and outputs use non-blocking assignments so every output is a clean register.
   always_ff @(posedge drp_dclk) begin
      if (!free_run_rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         drp_daddr <= '0;
         drp_di    <= '0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         pll_rst   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         drp_den <= 1'b0;
         drp_dwe <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  drp_daddr <= req_daddr;
                  req_ready <= 1'b0;
                  err       <= 1'b0;
                  err_code  <= '0;
                  pll_rst   <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= HOLD_LOAD;
                  state     <= HOLD;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt == 16'd0) begin
                  drp_den <= 1'b1;
                  state   <= RD;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            RD: begin
               cnt   <= 16'd1;
               state <= RD_WAIT;
            end
            WR: begin
               cnt   <= 16'd1;
               state <= WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
               if (drp_drdy) begin
                  if (state == RD_WAIT) begin
                     drp_di  <= (drp_do & mask_q) | (data_q & ~mask_q);
                     drp_den <= 1'b1;
                     drp_dwe <= 1'b1;
                     state   <= WR;
                  end else if (last_q) begin
                     pll_rst <= 1'b0;
                     state   <= RELEASE;
                  end else begin
                     req_ready <= 1'b1;
                     state     <= NEXT;
                  end
               end else if (cnt == DRDY_LIMIT) begin
                  // Abandon the sequence; any entries still queued upstream stay unconsumed.
                  err       <= 1'b1;
                  err_code  <= ERR_DRDY;
                  pll_rst   <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            NEXT: begin
               if (take) begin
                  drp_daddr <= req_daddr;
                  req_ready <= 1'b0;
                  drp_den   <= 1'b1;
                  state     <= RD;
               end
            end
            RELEASE: begin
               cnt   <= '0;
               state <= LOCK_WAIT;
            end
            LOCK_WAIT: begin
               // cnt == 0 marks the first cycle after release, where locked may still be stale.
               if (cnt != 16'd0 && locked) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else if (cnt == LOCK_LIMIT) begin
                  err       <= 1'b1;
                  err_code  <= ERR_LOCK;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl: a DRP/PLL model on the falling edge logs every
// transaction and pin event; each test task compares those logs with hand-computed values.
module tb_pll_drp_ctrl;
   localparam int LOCK_TO = 100;

   logic        drp_dclk      = 1'b0;
   logic        free_run_rstn = 1'b0;
   logic        req_valid     = 1'b0;
   logic        req_ready;
   logic [6:0]  req_daddr     = '0;
   logic [15:0] req_mask      = '0;
   logic [15:0] req_data      = '0;
   logic        req_last      = 1'b0;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di;
   logic [15:0] drp_do        = '0;
   logic        drp_den;
   logic        drp_dwe;
   logic        drp_drdy      = 1'b0;
   logic        pll_rst;
   logic        locked        = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   pll_drp_ctrl #(.DRDY_TIMEOUT(64), .RST_HOLD(4), .LOCK_TIMEOUT(LOCK_TO)) dut (
      .drp_dclk(drp_dclk), .free_run_rstn(free_run_rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_daddr(req_daddr),
      .req_mask(req_mask), .req_data(req_data), .req_last(req_last),
      .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_den(drp_den),
      .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .pll_rst(pll_rst), .locked(locked),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 drp_dclk = ~drp_dclk;

   // Knobs written only by the test tasks.
   int          drdy_lat   = 2;
   logic        drdy_mute  = 1'b0;
   logic        stray      = 1'b0;
   int          lock_delay = 10;
   logic [15:0] pll_mem [128];

   // Logs written only by the model.
   int          cyc_n = 0, pend = 0, lcnt = 0, log_n = 0;
   int          done_cnt = 0, done_cyc = 0, rst_rise_cyc = 0, rst_fall_cyc = 0;
   int          rst_fall_n = 0, lock_rise_cyc = 0;
   logic        rst_prev = 1'b0;
   logic [15:0] pend_do = '0;
   logic [6:0]  log_addr [64];
   logic        log_we   [64];
   logic [15:0] log_di   [64];
   int          log_cyc  [64];
   logic        busy_at_done = 1'b0, err_at_done = 1'b0, rst_at_done = 1'b0;
   logic [1:0]  code_at_done = '0;

   int n_vec = 0;
   int n_bad = 0;

   always @(negedge drp_dclk) begin
      cyc_n = cyc_n + 1;
      drp_drdy = 1'b0;
      if (!free_run_rstn) begin
         pend = 0;
      end else if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_do   = pend_do;
         end
      end
      if (drp_den) begin
         if (log_n < 64) begin
            log_addr[log_n] = drp_daddr;
            log_we[log_n]   = drp_dwe;
            log_di[log_n]   = drp_di;
            log_cyc[log_n]  = cyc_n;
         end
         log_n   = log_n + 1;
         pend_do = pll_mem[drp_daddr];
         if (!drdy_mute) pend = drdy_lat;
      end
      if (stray) drp_drdy = 1'b1;
      if (pll_rst && !rst_prev) rst_rise_cyc = cyc_n;
      if (!pll_rst && rst_prev) begin
         rst_fall_cyc = cyc_n;
         rst_fall_n   = rst_fall_n + 1;
      end
      rst_prev = pll_rst;
      if (pll_rst) begin
         lcnt   = 0;
         locked = 1'b0;
      end else begin
         if (lock_delay != 0 && lcnt == lock_delay && !locked) begin
            locked        = 1'b1;
            lock_rise_cyc = cyc_n;
         end
         if (lcnt < 100000) lcnt = lcnt + 1;
      end
      if (done) begin
         done_cnt     = done_cnt + 1;
         done_cyc     = cyc_n;
         busy_at_done = busy;
         err_at_done  = err;
         code_at_done = err_code;
         rst_at_done  = pll_rst;
      end
   end

   task automatic tick();
      @(negedge drp_dclk);
      #1;
   endtask

   task automatic send(input string name, input logic [6:0] a, input logic [15:0] m,
                       input logic [15:0] d, input logic l, input int late, output int hs);
      int t;
      t = 0;
      while (req_ready !== 1'b1 && t < 500) begin
         tick();
         t++;
      end
      if (req_ready !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_ready_timeout: req_ready=%b after %0d cycles, want 1", name, req_ready, t);
      end
      repeat (late) tick();
      req_daddr = a;
      req_mask  = m;
      req_data  = d;
      req_last  = l;
      req_valid = 1'b1;
      hs = cyc_n;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int base, t;
      base = done_cnt;
      t = 0;
      while (done_cnt == base && t < budget) begin
         tick();
         t++;
      end
      n_vec++;
      if (done_cnt == base) begin
         n_bad++;
         $display("FAIL %s_done_timeout: done_cnt=%0d after %0d cycles, want %0d", name, done_cnt, t, base + 1);
      end
   endtask

   task automatic test_reset();
      free_run_rstn = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({req_ready, drp_den, drp_dwe, pll_rst, busy, done, err, err_code, drp_daddr, drp_di} !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 00000000",
                  {req_ready, drp_den, drp_dwe, pll_rst, busy, done, err, err_code, drp_daddr, drp_di});
      end
      free_run_rstn = 1'b1;
      tick();
      n_vec++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready: ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
      end
   endtask

   task automatic test_single();
      int b, bd, hs;
      b = log_n;
      bd = done_cnt;
      pll_mem[7'h08] = 16'h5FFF;
      lock_delay = 10;
      send("single", 7'h08, 16'hF000, 16'h0145, 1'b1, 0, hs);
      wait_done("single", 200);
      repeat (3) tick();
      n_vec++;
      if (rst_rise_cyc !== hs + 1) begin
         n_bad++; $display("FAIL single_rst_rise: cycle %0d want %0d", rst_rise_cyc, hs + 1);
      end
      n_vec++;
      if (log_cyc[b] - rst_rise_cyc !== 4) begin
         n_bad++; $display("FAIL single_hold: read %0d cycles after pll_rst, want 4", log_cyc[b] - rst_rise_cyc);
      end
      n_vec++;
      if (log_n - b !== 2) begin
         n_bad++; $display("FAIL single_txn_count: got %0d want 2", log_n - b);
      end
      n_vec++;
      if (log_addr[b] !== 7'h08 || log_we[b] !== 1'b0) begin
         n_bad++; $display("FAIL single_read: addr=%h we=%b want addr=08 we=0", log_addr[b], log_we[b]);
      end
      n_vec++;
      if (log_addr[b+1] !== 7'h08 || log_we[b+1] !== 1'b1 || log_di[b+1] !== 16'h5145) begin
         n_bad++; $display("FAIL single_write: addr=%h we=%b di=%h want 08/1/5145", log_addr[b+1], log_we[b+1], log_di[b+1]);
      end
      n_vec++;
      if (log_cyc[b+1] - log_cyc[b] !== 3) begin
         n_bad++; $display("FAIL single_rd_to_wr: gap %0d want 3", log_cyc[b+1] - log_cyc[b]);
      end
      n_vec++;
      if (rst_fall_cyc !== log_cyc[b+1] + 3) begin
         n_bad++; $display("FAIL single_release: cycle %0d want %0d", rst_fall_cyc, log_cyc[b+1] + 3);
      end
      n_vec++;
      if (done_cyc !== lock_rise_cyc + 1) begin
         n_bad++; $display("FAIL single_done_latency: cycle %0d want %0d", done_cyc, lock_rise_cyc + 1);
      end
      n_vec++;
      if (done_cnt - bd !== 1 || err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
         n_bad++; $display("FAIL single_done: pulses=%0d err=%b busy=%b want 1/0/0", done_cnt - bd, err_at_done, busy_at_done);
      end
   endtask

   task automatic test_stray_mask();
      int b, hs;
      b = log_n;
      pll_mem[7'h14] = 16'hA5C3;
      stray = 1'b1;
      tick();
      tick();
      n_vec++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || drp_den !== 1'b0 || log_n !== b) begin
         n_bad++; $display("FAIL stray_idle: busy=%b ready=%b den=%b txns=%0d want 0/1/0/0", busy, req_ready, drp_den, log_n - b);
      end
      stray = 1'b0;
      send("mask", 7'h14, 16'hFFFF, 16'h1234, 1'b1, 0, hs);
      stray = 1'b1;
      tick();
      tick();
      stray = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || pll_rst !== 1'b1 || req_ready !== 1'b0 || log_n !== b) begin
         n_bad++; $display("FAIL stray_hold: busy=%b rst=%b ready=%b txns=%0d want 1/1/0/0", busy, pll_rst, req_ready, log_n - b);
      end
      wait_done("mask", 200);
      tick();
      n_vec++;
      if (log_cyc[b] - rst_rise_cyc !== 4 || rst_rise_cyc !== hs + 1) begin
         n_bad++; $display("FAIL stray_hold_len: read %0d cycles after pll_rst, want 4", log_cyc[b] - rst_rise_cyc);
      end
      n_vec++;
      if (log_we[b+1] !== 1'b1 || log_di[b+1] !== 16'hA5C3 || err_at_done !== 1'b0) begin
         n_bad++; $display("FAIL mask_ffff: we=%b di=%h err=%b want 1/a5c3/0", log_we[b+1], log_di[b+1], err_at_done);
      end
   endtask

   task automatic test_three();
      int b, bd, bf, hs0, hs1, hs2;
      logic [6:0]  exp_a [6] = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h14, 7'h14};
      logic [15:0] exp_w [3] = '{16'h11AB, 16'hBEEF, 16'hC3D3};
      b = log_n;
      bd = done_cnt;
      bf = rst_fall_n;
      pll_mem[7'h08] = 16'h1111;
      pll_mem[7'h09] = 16'h2222;
      pll_mem[7'h14] = 16'h3333;
      send("three0", 7'h08, 16'hFF00, 16'h00AB, 1'b0, 0, hs0);
      send("three1", 7'h09, 16'h0000, 16'hBEEF, 1'b0, 5, hs1);
      send("three2", 7'h14, 16'h0F0F, 16'hC0D0, 1'b1, 5, hs2);
      wait_done("three", 300);
      repeat (3) tick();
      n_vec++;
      if (log_n - b !== 6 || rst_rise_cyc !== hs0 + 1) begin
         n_bad++; $display("FAIL three_txn_count: got %0d want 6", log_n - b);
      end
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (log_addr[b+i] !== exp_a[i] || log_we[b+i] !== 1'(i % 2)) begin
            n_bad++; $display("FAIL three_order_%0d: addr=%h we=%b want %h/%0d", i, log_addr[b+i], log_we[b+i], exp_a[i], i % 2);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (log_di[b+2*i+1] !== exp_w[i]) begin
            n_bad++; $display("FAIL three_data_%0d: got %h want %h", i, log_di[b+2*i+1], exp_w[i]);
         end
      end
      n_vec++;
      if (log_cyc[b+2] !== hs1 + 1 || log_cyc[b+4] !== hs2 + 1) begin
         n_bad++; $display("FAIL three_next_latency: reads at %0d/%0d want %0d/%0d", log_cyc[b+2], log_cyc[b+4], hs1 + 1, hs2 + 1);
      end
      n_vec++;
      if (rst_fall_n - bf !== 1 || rst_fall_cyc <= log_cyc[b+5]) begin
         n_bad++; $display("FAIL three_rst_held: falls=%0d at %0d want 1 after %0d", rst_fall_n - bf, rst_fall_cyc, log_cyc[b+5]);
      end
      n_vec++;
      if (done_cnt - bd !== 1 || err_at_done !== 1'b0) begin
         n_bad++; $display("FAIL three_done: pulses=%0d err=%b want 1/0", done_cnt - bd, err_at_done);
      end
   endtask

   task automatic test_drdy_timeout();
      int b, hs;
      b = log_n;
      drdy_mute = 1'b1;
      send("drdy_to", 7'h08, 16'h0000, 16'h0001, 1'b1, 0, hs);
      wait_done("drdy_to", 200);
      drdy_mute = 1'b0;
      tick();
      n_vec++;
      if (done_cyc - log_cyc[b] !== 64 || log_n - b !== 1) begin
         n_bad++; $display("FAIL drdy_to_timing: done %0d cycles after den, txns=%0d want 64/1", done_cyc - log_cyc[b], log_n - b);
      end
      n_vec++;
      if (err_at_done !== 1'b1 || code_at_done !== 2'd1 || rst_at_done !== 1'b0) begin
         n_bad++; $display("FAIL drdy_to_flags: err=%b code=%0d rst=%b want 1/1/0", err_at_done, code_at_done, rst_at_done);
      end
      send("drdy_clr", 7'h09, 16'hFFFF, 16'h0000, 1'b1, 0, hs);
      n_vec++;
      if (err !== 1'b0 || err_code !== 2'd0 || rst_rise_cyc !== hs + 1) begin
         n_bad++; $display("FAIL drdy_to_clear: err=%b code=%0d want 0/0", err, err_code);
      end
      wait_done("drdy_clr", 200);
      tick();
   endtask

   task automatic test_lock_timeout();
      int hs;
      lock_delay = 0;
      send("lock_to", 7'h08, 16'hFFFF, 16'h0000, 1'b1, 0, hs);
      wait_done("lock_to", 400);
      lock_delay = 10;
      repeat (5) tick();
      n_vec++;
      if (done_cyc !== rst_fall_cyc + LOCK_TO + 1 || rst_rise_cyc !== hs + 1) begin
         n_bad++; $display("FAIL lock_to_timing: done at %0d want %0d", done_cyc, rst_fall_cyc + LOCK_TO + 1);
      end
      n_vec++;
      if (err_at_done !== 1'b1 || code_at_done !== 2'd2 || err !== 1'b1) begin
         n_bad++; $display("FAIL lock_to_flags: err=%b code=%0d sticky=%b want 1/2/1", err_at_done, code_at_done, err);
      end
   endtask

   task automatic test_reset_mid();
      int b, bd, hs, t;
      b = log_n;
      bd = done_cnt;
      drdy_lat = 20;
      pll_mem[7'h09] = 16'h2222;
      send("rstmid", 7'h08, 16'h0000, 16'h0F0F, 1'b1, 0, hs);
      t = 0;
      while (log_n < b + 2 && t < 200) begin
         tick();
         t++;
      end
      n_vec++;
      if (log_n < b + 2 || rst_rise_cyc !== hs + 1) begin
         n_bad++; $display("FAIL rstmid_write_timeout: txns=%0d want 2", log_n - b);
      end
      tick();
      free_run_rstn = 1'b0;
      tick();
      n_vec++;
      if ({req_ready, drp_den, drp_dwe, pll_rst, busy, done, err, err_code, drp_daddr, drp_di} !== 32'd0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %h want 00000000",
                  {req_ready, drp_den, drp_dwe, pll_rst, busy, done, err, err_code, drp_daddr, drp_di});
      end
      tick();
      free_run_rstn = 1'b1;
      drdy_lat = 2;
      repeat (30) tick();
      n_vec++;
      if (done_cnt !== bd || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_no_done: pulses=%0d ready=%b want 0/1", done_cnt - bd, req_ready);
      end
      send("rstmid_fresh", 7'h09, 16'h00FF, 16'h7700, 1'b1, 0, hs);
      wait_done("rstmid_fresh", 200);
      tick();
      n_vec++;
      if (log_di[log_n-1] !== 16'h7722 || err_at_done !== 1'b0 || done_cnt !== bd + 1) begin
         n_bad++; $display("FAIL rstmid_fresh: di=%h err=%b pulses=%0d want 7722/0/1", log_di[log_n-1], err_at_done, done_cnt - bd);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stray_mask();
      test_three();
      test_drdy_timeout();
      test_lock_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
